// File: rtl/uart_tx_scheduler_pkg.sv
// uart_tx_scheduler_pkg: shared state encoding and frame constants for the
// two-requester UART transmit scheduler.
package uart_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    localparam int FRAME_BITS           = 10;
    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 521;

    function automatic int cnt_width(input int clks);
        return (clks < 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/baud_tick_counter.sv
// baud_tick_counter: counts clocks within one serial bit and flags the last
// clock of the bit; reloads to 0 at every bit boundary.
module baud_tick_counter #(
    parameter int CLKS_PER_BIT = 521,
    parameter int W            = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic         tick,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == W'(CLKS_PER_BIT - 1));
    assign cnt  = cnt_q;

    always_comb
        cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + W'(1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter between two byte requesters feeding
// a single 8N1 UART transmitter with registered tx and status outputs.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant_id,
    output logic       frame_done
);

    localparam int           W   = cnt_width(CLKS_PER_BIT);
    localparam logic [W-1:0] PRE = W'(CLKS_PER_BIT - 2);

    state_e       state_q, state_d;
    logic [7:0]   data_q, data_d;
    logic [2:0]   bit_q, bit_d;
    logic         tx_q, tx_d;
    logic         busy_q, busy_d;
    logic         grant_q, grant_d;
    logic         prio_q, prio_d;
    logic         done_q, done_d;
    logic         tick, idle, win1, acc;
    logic [W-1:0] cnt;

    baud_tick_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .W           (W)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (!idle),
        .clr  (idle),
        .tick (tick),
        .cnt  (cnt)
    );

    // prio_q set means requester 1 wins a tie
    assign idle       = (state_q == IDLE);
    assign win1       = req1_valid && (!req0_valid || prio_q);
    assign req1_ready = idle && win1;
    assign req0_ready = idle && req0_valid && !win1;
    assign acc        = req0_ready || req1_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: if (acc) begin
                state_d = START;
                data_d  = win1 ? req1_data : req0_data;
                grant_d = win1;
                prio_d  = !win1;
                tx_d    = 1'b0;
                busy_d  = 1'b1;
            end
            START: if (tick) begin
                state_d = DATA;
                bit_d   = 3'd0;
                tx_d    = data_q[0];
            end
            DATA: if (tick) begin
                state_d = (bit_q == 3'(DATA_BITS - 1)) ? STOP : DATA;
                bit_d   = bit_q + 3'd1;
                tx_d    = (bit_q == 3'(DATA_BITS - 1)) ? 1'b1 : data_q[bit_q + 3'd1];
            end
            STOP: begin
                // registered pulse lands on the final stop-bit clock
                done_d = (cnt == PRE);
                if (tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= 8'h00;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            done_q  <= done_d;
        end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: randomized requesters checked cycle by cycle against
// a frame-position reference model of arbitration and the serial waveform.
module tb_uart_tx_scheduler;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_ready, req1_ready, tx, busy, grant_id, frame_done;

    int         n_chk = 0, n_fail = 0;
    int         t = 0;
    bit         mg = 1'b0, mprio = 1'b0, e0, e1, hs0, hs1, drop_ok = 1'b0;
    logic [7:0] mb = 8'h00;
    int         p0 = 0, p1 = 0;

    uart_tx_scheduler #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // frame cycle k (1..FRAME): start bit, 8 data bits LSB first, stop bit
    function automatic logic exp_tx(input int k, input logic [7:0] b);
        int i;
        i = (k - 1) / CPB;
        return (i == 0) ? 1'b0 : (i > 8) ? 1'b1 : b[i-1];
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            t = 0;
            mprio = 1'b0;
            mg = 1'b0;
        end
        e1 = req1_valid && (!req0_valid || mprio);
        e0 = req0_valid && !e1;
        check("ready0", req0_ready, (t == 0) && e0);
        check("ready1", req1_ready, (t == 0) && e1);
        check("busy", busy, t != 0);
        check("tx", tx, (t == 0) ? 1'b1 : exp_tx(t, mb));
        check("frame_done", frame_done, t == FRAME);
        check("grant_id", grant_id, mg);
        hs0 = req0_valid && req0_ready && rst_n;
        hs1 = req1_valid && req1_ready && rst_n;
        if (rst_n) begin
            if (t == 0) begin
                if (e0 || e1) begin
                    t = 1;
                    mg = e1;
                    mb = e1 ? req1_data : req0_data;
                    mprio = !e1;
                end
            end else
                t = (t == FRAME) ? 0 : t + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (hs0 || !req0_valid) begin
                req0_valid = ($urandom_range(99) < p0);
                req0_data  = 8'($urandom);
            end else if (drop_ok && $urandom_range(7) == 0)
                req0_valid = 1'b0;
            if (hs1 || !req1_valid) begin
                req1_valid = ($urandom_range(99) < p1);
                req1_data  = 8'($urandom);
            end else if (drop_ok && $urandom_range(7) == 0)
                req1_valid = 1'b0;
        end
    endtask

    task automatic wait_t(input int target, input int budget);
        for (int i = 0; i < budget && t != target; i++) step(1);
        check("wait_frame_pos", t, target);
    endtask

    initial begin
        step(3);
        rst_n = 1'b1;
        step(2);
        // lone req0 0x55
        req0_valid = 1'b1;
        req0_data  = 8'h55;
        step(FRAME + 5);
        // both requesters continuously from reset
        rst_n = 1'b0;
        p0 = 100;
        p1 = 100;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(4 * (FRAME + 1) + 2);
        // req1 only
        p0 = 0;
        req0_valid = 1'b0;
        step(3 * (FRAME + 1) + 5);
        // reset during data bit 3 with req0 pending
        p1 = 0;
        wait_t(0, 2 * FRAME);
        p0 = 100;
        req0_valid = 1'b1;
        req0_data  = 8'($urandom);
        wait_t(2 + 4 * CPB, 2 * FRAME);
        rst_n = 1'b0;
        #1;
        check("async_tx", tx, 1'b1);
        check("async_busy", busy, 1'b0);
        check("async_done", frame_done, 1'b0);
        step(3);
        rst_n = 1'b1;
        step(1);
        check("post_reset_accept", busy, 1'b1);
        check("post_reset_grant", grant_id, 1'b0);
        // req0 raised while busy, bytes 0x00 and 0xFF
        p0 = 0;
        wait_t(0, 3 * FRAME);
        step(1);
        wait_t(0, 3 * FRAME);
        req1_valid = 1'b1;
        req1_data  = 8'hA3;
        step(10);
        req0_valid = 1'b1;
        req0_data  = 8'h00;
        step(2 * FRAME + 5);
        req1_valid = 1'b1;
        req1_data  = 8'h3C;
        step(10);
        req0_valid = 1'b1;
        req0_data  = 8'hFF;
        step(2 * FRAME + 5);
        // random traffic with withdrawals
        drop_ok = 1'b1;
        repeat (20) begin
            p0 = int'($urandom_range(100));
            p1 = int'($urandom_range(100));
            step(200);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 521, clocks per serial bit (9600 baud at 5 MHz); legal range >= 2.
REQ-002 SHALL have port clk  input  1  clock; all flops on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req0_valid  input  1  requester 0 (keyboard ASCII path) has a byte.
REQ-005 SHALL have port req0_data  input  8  requester 0 byte.
REQ-006 SHALL have port req0_ready  output  1  requester 0 byte accepted this cycle when valid.
REQ-007 SHALL have port req1_valid  input  1  requester 1 (echo/status path) has a byte.
REQ-008 SHALL have port req1_data  input  8  requester 1 byte.
REQ-009 SHALL have port req1_ready  output  1  requester 1 byte accepted this cycle when valid.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port grant_id  output  1  requester owning the current or last frame.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse on final stop-bit cycle.

Function
REQ-014 SHALL implement states IDLE, START, DATA, STOP.
REQ-015 In IDLE, SHALL assert readyX combinationally only for the arbitration winner, and only when IDLE; acceptance = valid && ready.
REQ-016 Arbitration SHALL be round-robin: single valid requester wins; both valid -> requester not granted last wins; after reset req0 has priority.
REQ-017 On acceptance SHALL latch data and grant_id, go to START next cycle; requester data need not stay stable afterwards.
REQ-018 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA SHALL drive 8 bits LSB first, each CLKS_PER_BIT cycles, 3-bit bit counter, then STOP.
REQ-020 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, pulse frame_done on its last cycle, then return to IDLE.
REQ-021 Frame SHALL occupy exactly 10*CLKS_PER_BIT cycles; minimum accept-to-accept spacing 10*CLKS_PER_BIT+1 cycles (one IDLE cycle mandatory).
REQ-022 busy SHALL be 1 in START/DATA/STOP, 0 in IDLE; both ready outputs SHALL be 0 while busy.
REQ-023 Valid deasserted before acceptance SHALL leave no state change; valid during busy SHALL be held off, not dropped by the block.
REQ-024 Baud counter width SHALL be clog2(CLKS_PER_BIT); counter SHALL reload to 0 at each bit boundary, never wrap mid-bit.
REQ-025 tx SHALL be registered (glitch-free).

Reset
REQ-026 Asserting rst_n low SHALL immediately force: state IDLE, tx=1, busy=0, frame_done=0, grant_id=0, RR pointer to req0, counters 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no frame_done; first accept possible on first rising edge after release.

Structure
REQ-028 Shared package SHALL hold state enum, FRAME_BITS=10, DEFAULT_CLKS_PER_BIT=521.
REQ-029 SHALL instantiate one sub-module baud_tick_counter (enable, clear, bit-end tick output).

Verification (CLKS_PER_BIT=4)
REQ-030 req0 0x55 alone -> req0_ready same cycle, tx 0,1,0,1,0,1,0,1,0,1 each 4 cycles, frame_done 40 cycles after accept, grant_id=0.
REQ-031 Both valid continuously from reset -> grants 0,1,0,1, accepts 41 cycles apart.
REQ-032 req1 only, continuous -> every grant req1, grant_id=1, no req0_ready.
REQ-033 rst_n low during DATA bit 3 -> tx=1 and busy=0 asynchronously, no frame_done; after release pending req0 accepted next edge.
REQ-034 req0 valid raised during busy -> req0_ready 0 until IDLE cycle, then accepted; bytes 0x00 and 0xFF -> eight 0s / eight 1s between start and stop.
